mac_accum_pe: RTL
=================

MAC_ACCUM_PE -- requirements
Module: mac_accum_pe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: operand width of in1, in2 and fwd_out.
REQ-002 The block SHALL have parameter ACC_W, default 24: accumulator and result width; ACC_W >= 2*DATA_W.
REQ-003 The block SHALL have parameter CNT_W, default 8: width of the beat-count field len.
REQ-004 The block SHALL have parameter SIGNED, default 0: 0 treats operands as unsigned, 1 as two's-complement.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset; it is synchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit: a job request, sampled only in IDLE.
REQ-008 The block SHALL have port len, input, CNT_W bits: the number of MAC beats in the job, sampled with start.
REQ-009 The block SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the operand handshake.
REQ-010 The block SHALL have ports in1 and in2, input, DATA_W bits each: the operands.
REQ-011 The block SHALL have port fwd_out, output, DATA_W bits: in2 of the last accepted beat, passed to the next PE.
REQ-012 The block SHALL have port fwd_valid, output, 1 bit: a one-cycle strobe marking a new fwd_out.
REQ-013 The block SHALL have ports res_valid (output, 1 bit) and res_ready (input, 1 bit): the result handshake.
REQ-014 The block SHALL have port res_data, output, ACC_W bits: the final accumulated sum.
REQ-015 The block SHALL have port res_sat, output, 1 bit: set if saturation occurred anywhere in the job.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCUM and DONE.
REQ-018 In IDLE, start=1 with len!=0 SHALL clear acc, clear the sticky saturation flag, load cnt=len and move to ACCUM on the next cycle.
REQ-019 In IDLE, start=1 with len==0 SHALL be ignored; the block stays in IDLE.
REQ-020 start SHALL be ignored in ACCUM and DONE.
REQ-021 in_ready SHALL be 1 only in ACCUM; a beat is a cycle with in_valid=1 and in_ready=1.
REQ-022 On each beat: acc <= sat(acc + ext(in1*in2)) and cnt <= cnt-1.
- The product is a full 2*DATA_W-bit result, sign-extended to ACC_W if SIGNED=1, zero-extended otherwise.
REQ-023 Saturation SHALL behave as follows, and any clamp sets the sticky flag:
- SIGNED=0: clamp at 2^ACC_W-1.
- SIGNED=1: clamp at +(2^(ACC_W-1)-1) and at -2^(ACC_W-1).
REQ-024 Once acc is saturated, later beats SHALL still apply the sum-then-clamp rule (no wrap-around ever occurs).
REQ-025 On the beat with cnt==1, the FSM SHALL move to DONE and register res_data = the new acc and res_sat = the sticky flag; res_valid rises the cycle after the last beat.
REQ-026 In DONE, res_valid SHALL be 1 and res_data/res_sat SHALL hold stable until res_valid&res_ready, then the FSM returns to IDLE on the next cycle.
REQ-027 In DONE, res_valid SHALL be 0 the cycle after the handshake.
REQ-028 A cycle with in_valid=1 but no beat (not ACCUM) SHALL change nothing.
REQ-029 On every beat, fwd_out <= in2 and fwd_valid <= 1; in any cycle without a beat, fwd_valid <= 0 and fwd_out holds its value.
REQ-030 in_ready, res_valid and busy SHALL be decoded from registered state only, with no combinational path from any input.

Reset
REQ-031 With rst=1 at a clock edge, the block SHALL set state=IDLE and acc=0, cnt=0, res_data=0, res_sat=0, the sticky flag=0, fwd_out=0 and fwd_valid=0.
- Consequently in_ready=0, res_valid=0 and busy=0.
REQ-032 rst SHALL take priority over every other input; a job in ACCUM or DONE is discarded without emitting a result.
REQ-033 After rst deasserts, the block SHALL accept start on the first following edge.

Verification
REQ-034 The bench SHALL cover an unsigned dot product with defaults:
- start, len=3; beats (2,3), (4,5), (255,255).
- Required: res_data=65051, res_sat=0; res_valid rises exactly 1 cycle after beat 3.
REQ-035 The bench SHALL cover stalls and backpressure:
- len=2 with in_valid low for 3 cycles between the beats; acc unchanged during the gap; result=sum of the 2 products.
- res_ready held low 4 cycles; res_data stable and busy=1 throughout; IDLE one cycle after res_ready=1.
REQ-036 The bench SHALL cover saturation with ACC_W=16, SIGNED=0:
- beats (255,255) then (255,255).
- Required: res_data=65535, res_sat=1.
- The next job with len=1 and beat (1,1) gives res_data=1, res_sat=0.
REQ-037 The bench SHALL cover signed mode with SIGNED=1:
- beats (-128,127) then (3,-2) (8'h80,8'h7F; 8'h03,8'hFE).
- Required: res_data=-16262 sign-extended to ACC_W.
REQ-038 The bench SHALL cover forwarding and ignored requests:
- Every beat yields fwd_out=in2 with a one-cycle fwd_valid.
- start with len=0 keeps busy=0.
- start asserted during ACCUM does not alter cnt.
REQ-039 The bench SHALL cover reset mid-job: rst for 1 cycle after beat 2 of len=4 gives all outputs 0 and IDLE, and a fresh len=1 job (7,6) gives 42.

Source files
------------

// File: rtl/mac_accum_pe.sv
// Multiply-accumulate processing element: runs a job of len operand beats,
// accumulates with saturation, forwards in2 downstream and returns the sum.
module mac_accum_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] fwd_out,
    output logic              fwd_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_sat,
    output logic              busy
);

    localparam int               PAD_W     = ACC_W + 1 - 2 * DATA_W;
    localparam logic             IS_SIGNED = (SIGNED != 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [ACC_W-1:0] U_MAX     = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] S_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] S_MIN     = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sticky_q;
    logic [ACC_W-1:0]    res_data_q;
    logic                res_sat_q;
    logic [DATA_W-1:0]   fwd_out_q;
    logic                fwd_valid_q;

    logic                beat_s;
    logic                load_s;
    logic [2*DATA_W-1:0] op1_s, op2_s, prod_s;
    logic [ACC_W:0]      prod_ext_s, acc_ext_s, sum_s;
    logic [ACC_W-1:0]    acc_next_s;
    logic                clamp_s;

    assign beat_s = in_valid & (state_q == ACCUM);
    assign load_s = start & (state_q == IDLE) & (len != CNT_ZERO);

    // The low 2*DATA_W bits of a product of extended operands are exact in both modes.
    assign op1_s      = {{DATA_W{IS_SIGNED & in1[DATA_W-1]}}, in1};
    assign op2_s      = {{DATA_W{IS_SIGNED & in2[DATA_W-1]}}, in2};
    assign prod_s     = op1_s * op2_s;
    assign prod_ext_s = {{PAD_W{IS_SIGNED & prod_s[2*DATA_W-1]}}, prod_s};
    assign acc_ext_s  = {IS_SIGNED & acc_q[ACC_W-1], acc_q};
    assign sum_s      = acc_ext_s + prod_ext_s;

    // Sum-then-clamp using one guard bit above the accumulator.
    always_comb begin
        clamp_s    = 1'b0;
        acc_next_s = sum_s[ACC_W-1:0];
        if (IS_SIGNED) begin
            if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
                clamp_s    = 1'b1;
                acc_next_s = sum_s[ACC_W] ? S_MIN : S_MAX;
            end else begin
                clamp_s    = 1'b0;
                acc_next_s = sum_s[ACC_W-1:0];
            end
        end else if (sum_s[ACC_W]) begin
            clamp_s    = 1'b1;
            acc_next_s = U_MAX;
        end else begin
            clamp_s    = 1'b0;
            acc_next_s = sum_s[ACC_W-1:0];
        end
    end

    // Job sequencing: idle until a non-empty job, accumulate, then hold the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load_s) begin
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (beat_s && (cnt_q == CNT_ONE)) begin
                    state_d = DONE;
                end else begin
                    state_d = ACCUM;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator, beat counter, captured result and forwarding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= CNT_ZERO;
            sticky_q    <= 1'b0;
            res_data_q  <= {ACC_W{1'b0}};
            res_sat_q   <= 1'b0;
            fwd_out_q   <= {DATA_W{1'b0}};
            fwd_valid_q <= 1'b0;
        end else begin
            if (load_s) begin
                acc_q    <= {ACC_W{1'b0}};
                sticky_q <= 1'b0;
                cnt_q    <= len;
            end else if (beat_s) begin
                acc_q    <= acc_next_s;
                sticky_q <= sticky_q | clamp_s;
                cnt_q    <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    res_data_q <= acc_next_s;
                    res_sat_q  <= sticky_q | clamp_s;
                end
            end
            fwd_valid_q <= beat_s;
            if (beat_s) begin
                fwd_out_q <= in2;
            end
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_data  = res_data_q;
    assign res_sat   = res_sat_q;
    assign fwd_out   = fwd_out_q;
    assign fwd_valid = fwd_valid_q;

endmodule
